// File: rtl/wb_rr_arbiter.sv
// Wishbone B4 classic N-master to 1-slave round-robin arbiter.
// Ownership spans a whole cyc; an optional watchdog turns hung strobes into err.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int BUS_GRANULARITY = 8,
  parameter int TIMEOUT         = 0,
  localparam int SEL_WIDTH      = DATA_WIDTH / BUS_GRANULARITY
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic                              s_we_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              state_dbg
);

  // Handshake: a master requests with cyc (held for the whole transaction) and
  // stb per beat; a beat completes in the cycle the slave raises ack/err/rty.

  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          owner, owner_nxt;
  logic [IW-1:0]          last, last_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [IW-1:0]          pick;
  logic                   pick_found;
  int                     pick_idx;
  logic                   own_cyc, own_stb;
  logic                   wd_fire;

  assign own_cyc   = m_cyc_i[owner];
  assign own_stb   = m_stb_i[owner];
  assign grant_o   = grant;
  assign state_dbg = (state == OWNED);
  assign m_dat_o   = s_dat_i;

  // First requester strictly after the previous owner, wrapping around.
  always_comb begin
    pick       = last;
    pick_found = 1'b0;
    pick_idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pick_idx = (int'(last) + k) % NUM_MASTERS;
      if (!pick_found && m_cyc_i[pick_idx]) begin
        pick_found = 1'b1;
        pick       = IW'(pick_idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (|m_cyc_i) begin
          state_nxt = OWNED;
          owner_nxt = pick;
          last_nxt  = pick;
          grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(NUM_MASTERS - 1);
      grant <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state == OWNED) begin
      s_adr_o        = m_adr_i[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o        = m_dat_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      s_we_o         = m_we_i[owner];
      s_sel_o        = m_sel_i[int'(owner)*SEL_WIDTH +: SEL_WIDTH];
      s_stb_o        = own_stb & ~wd_fire;
      s_cyc_o        = own_cyc;
      m_ack_o[owner] = s_ack_i;
      m_err_o[owner] = s_err_i | wd_fire;
      m_rty_o[owner] = s_rty_i;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] wd_cnt;
      logic          wd_hit;

      // Fires in the TIMEOUT-th consecutive unterminated strobe cycle; a real
      // slave termination in that same cycle wins over the watchdog.
      assign wd_hit  = (state == OWNED) && own_stb && !(s_ack_i || s_err_i || s_rty_i);
      assign wd_fire = wd_hit && (wd_cnt == CW'(TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (rst || !wd_hit || wd_fire) begin
          wd_cnt <= '0;
        end else begin
          wd_cnt <= wd_cnt + CW'(1);
        end
      end
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: reset, arbitration, burst lock, read path,
// watchdog (TIMEOUT=8 and TIMEOUT=0 side by side), reset mid-transfer, round-robin.
module tb_wb_rr_arbiter;

  localparam int NM = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM-1:0]    m_we, m_stb, m_cyc;
  logic [NM*SW-1:0] m_sel;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack, s_err, s_rty;

  logic [DW-1:0] m_dat_o,  nt_m_dat_o;
  logic [NM-1:0] m_ack_o,  m_err_o,  m_rty_o,  grant;
  logic [NM-1:0] nt_m_ack_o, nt_m_err_o, nt_m_rty_o, nt_grant;
  logic [AW-1:0] s_adr_o,  nt_s_adr_o;
  logic [DW-1:0] s_dat_o,  nt_s_dat_o;
  logic [SW-1:0] s_sel_o,  nt_s_sel_o;
  logic          s_we_o, s_stb_o, s_cyc_o, state_dbg;
  logic          nt_s_we_o, nt_s_stb_o, nt_s_cyc_o, nt_state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [NM-1:0] exp_q[$];
  logic [NM-1:0] exp_grant;

  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BUS_GRANULARITY(8), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .state_dbg(state_dbg)
  );

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BUS_GRANULARITY(8), .TIMEOUT(0)
  ) dut_nt (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(nt_m_dat_o), .m_we_i(m_we),
    .m_sel_i(m_sel), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
    .m_ack_o(nt_m_ack_o), .m_err_o(nt_m_err_o), .m_rty_o(nt_m_rty_o),
    .s_adr_o(nt_s_adr_o), .s_dat_o(nt_s_dat_o), .s_we_o(nt_s_we_o), .s_sel_o(nt_s_sel_o),
    .s_stb_o(nt_s_stb_o), .s_cyc_o(nt_s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(nt_grant), .state_dbg(nt_state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a);
    m_cyc[i]           = c;
    m_stb[i]           = s;
    m_we[i]            = w;
    m_adr[i*AW +: AW]  = a;
    m_dat[i*DW +: DW]  = a ^ 32'hA5A5_0000;
    m_sel[i*SW +: SW]  = 4'hF;
  endtask

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_we = '0; m_stb = '0; m_cyc = '0; m_sel = '0;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;

    // reset defaults
    next(); next(); #2;
    check("rst_grant", grant, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_stb", s_stb_o, 0);
    check("rst_s_adr", s_adr_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    check("rst_rty", m_rty_o, 0);
    check("rst_state", state_dbg, 0);
    check("rst_nt_grant", nt_grant, 0);

    // masters 0 and 1 request together: master 0 wins one cycle later
    next(); rst = 1'b0;
    drive(0, 1, 1, 1, 32'h100);
    drive(1, 1, 1, 0, 32'h200);
    #2; check("arb_idle_grant", grant, 0);
    next(); s_ack = 1'b1; #2;
    check("arb_grant", grant, 3'b001);
    check("arb_state", state_dbg, 1);
    check("arb_s_adr", s_adr_o, 32'h100);
    check("arb_s_cyc", s_cyc_o, 1);
    check("arb_s_we", s_we_o, 1);
    check("arb_s_dat", s_dat_o, 32'h100 ^ 32'hA5A5_0000);
    check("arb_s_sel", s_sel_o, 4'hF);
    check("arb_ack", m_ack_o, 3'b001);

    // owner 0 drops cyc: s_cyc low immediately, idle next, master 1 after that
    next(); s_ack = 1'b0; drive(0, 0, 0, 0, 32'h0); #2;
    check("rel_s_cyc", s_cyc_o, 0);
    check("rel_grant_held", grant, 3'b001);
    next(); #2;
    check("rel_idle_grant", grant, 0);

    // read data to master 1, isolated from others
    next(); s_dat_i = 32'hDEAD_BEEF; s_ack = 1'b1; #2;
    check("rd_grant", grant, 3'b010);
    check("rd_ack", m_ack_o, 3'b010);
    check("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    check("rd_s_we", s_we_o, 0);

    // burst lock: master 1 keeps cyc for 4 beats while master 0 requests
    drive(0, 1, 1, 0, 32'h300);
    for (int b = 0; b < 4; b++) begin
      next(); drive(1, 1, 1, 1, AW'((b + 1) * 16)); s_ack = 1'b1; #2;
      check("burst_adr", s_adr_o, (b + 1) * 16);
      check("burst_grant", grant, 3'b010);
      check("burst_ack", m_ack_o, 3'b010);
    end
    next(); s_ack = 1'b0; drive(1, 0, 0, 0, 32'h0); #2;
    check("burst_rel_grant", grant, 3'b010);
    check("burst_rel_ack", m_ack_o, 0);
    next(); #2;
    check("burst_idle", grant, 0);
    next(); #2;
    check("burst_next_grant", grant, 3'b001);
    check("burst_next_adr", s_adr_o, 32'h300);
    next(); drive(0, 0, 0, 0, 32'h0); #2;
    check("m0_drop_s_cyc", s_cyc_o, 0);

    // watchdog: master 1 strobes, slave never answers
    next(); drive(1, 1, 1, 0, 32'h55); #2;
    check("wd_idle", grant, 0);
    for (int c = 1; c <= 16; c++) begin
      next(); #2;
      if (c == 1) check("wd_grant", grant, 3'b010);
      if (c == 8 || c == 16) begin
        check("wd_err", m_err_o, 3'b010);
        check("wd_stb_mask", s_stb_o, 0);
        check("wd_grant_kept", grant, 3'b010);
        check("nt_no_err", nt_m_err_o, 0);
        check("nt_stb", nt_s_stb_o, 1);
      end else if (c == 1 || c == 7 || c == 9 || c == 15) begin
        check("wd_quiet_err", m_err_o, 0);
        check("wd_quiet_stb", s_stb_o, 1);
      end
    end

    // reset during master 1's unacked strobe
    next(); rst = 1'b1; #2;
    check("mid_pre_grant", grant, 3'b010);
    next(); rst = 1'b0;
    drive(0, 1, 1, 0, 32'hA00);
    drive(1, 1, 1, 0, 32'hA01);
    drive(2, 1, 1, 0, 32'hA02);
    #2;
    check("mid_s_cyc", s_cyc_o, 0);
    check("mid_grant", grant, 0);
    check("mid_err", m_err_o, 0);
    check("mid_state", state_dbg, 0);

    // round-robin with all three requesting; each owner does one beat
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    for (int r = 0; r < 4; r++) begin
      next(); s_ack = 1'b1; #2;
      exp_grant = exp_q.pop_front();
      check("rr_grant", grant, exp_grant);
      check("rr_ack", m_ack_o, exp_grant);
      next(); s_ack = 1'b0; drive(r % NM, 0, 0, 0, 32'h0); #2;
      next(); drive(r % NM, 1, 1, 0, AW'(32'hA00 + (r % NM))); #2;
      check("rr_gap", grant, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
